// File: rtl/memory_access.sv
// memory_access: pipeline stage between execute and writeback.
//   Runs loads and stores on a req/ack data bus and stalls upstream while a
//   transaction is outstanding. Presents a forwarding record (data.valid/
//   address/data) to writeback and the hazard unit.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   stage_in/out       stage_status_t from execute / to writeback
//   next_ready         writeback accepts stage_out this cycle
//   mem_req/we/addr/wdata/wstrb   bus request (held until mem_ack)
//   mem_ack/rdata      bus completion and load word (same cycle)
//   mem_error          one-cycle pulse on timeout or misalignment abort
// Parameter TIMEOUT_CYCLES: REQ cycles without ack before abort (0 = never).
// Optional macro MEMORY_ACCESS_MISALIGN_EN: abort misaligned H/W accesses
// without a bus request instead of silently dropping the low address bits.

package memory_access_pkg;
    typedef enum logic [1:0] {MEM_NONE = 2'd0, MEM_LOAD = 2'd1, MEM_STORE = 2'd2} mem_op_t;
    typedef enum logic [1:0] {MEM_B = 2'd0, MEM_H = 2'd1, MEM_W = 2'd2} mem_size_t;
    typedef enum logic [1:0] {RD_ALU = 2'd0, RD_MEMORY = 2'd1, RD_PC = 2'd2} rd_src_t;

    typedef struct packed {
        logic [31:0] raw;
        logic [4:0]  rd;
        rd_src_t     reg_rd_src;
        mem_op_t     mem_op;
        mem_size_t   mem_size;
        logic        mem_unsigned;
    } instruction_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  address;
        logic [31:0] data;
    } fwd_data_t;

    typedef struct packed {
        logic         valid;
        logic         ready;
        logic [31:0]  pc;
        instruction_t instruction;
        logic [31:0]  reg_rd1;
        logic [31:0]  reg_rd2;
        fwd_data_t    data;
    } stage_status_t;
endpackage

module memory_access
    import memory_access_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  stage_status_t stage_in,
    output stage_status_t stage_out,
    input  logic          next_ready,
    output logic          mem_req,
    output logic          mem_we,
    output logic [31:0]   mem_addr,
    output logic [31:0]   mem_wdata,
    output logic [3:0]    mem_wstrb,
    input  logic          mem_ack,
    input  logic [31:0]   mem_rdata,
    output logic          mem_error
);
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    state_t       state_q, state_d;
    logic [31:0]  pc_q, pc_d, rd1_q, rd1_d, rd2_q, rd2_d, out_data_q, out_data_d;
    instruction_t instr_q, instr_d;
    logic         in_dvalid_q, in_dvalid_d, abort_q, abort_d;
    logic [1:0]   off_q, off_d;
    logic         req_q, req_d, we_q, we_d, err_q, err_d;
    logic [31:0]  addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]   wstrb_q, wstrb_d;
    logic [CW-1:0] tmo_q, tmo_d;

    logic        ready, capture, misalign, timeout_hit;
    logic [1:0]  in_off;
    logic [31:0] in_addr, rs2, load_res, b_word, h_word;

    logic unused_in;
    assign unused_in = stage_in.ready;

    assign ready   = (state_q == S_IDLE) || ((state_q == S_DONE) && next_ready);
    assign capture = stage_in.valid && ready;
    assign in_addr = stage_in.data.data;
    assign in_off  = in_addr[1:0];
    assign rs2     = stage_in.reg_rd2;

`ifdef MEMORY_ACCESS_MISALIGN_EN
    assign misalign = (stage_in.instruction.mem_op != MEM_NONE) &&
                      (((stage_in.instruction.mem_size == MEM_H) && in_off[0]) ||
                       ((stage_in.instruction.mem_size == MEM_W) && (in_off != 2'b00)));
`else
    assign misalign = 1'b0;
`endif

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_tmo
            assign timeout_hit = (tmo_q == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_tmo
            assign timeout_hit = 1'b0;
        end
    endgenerate

    // Lane extraction: shift the addressed byte/halfword down to bit 0.
    assign b_word = mem_rdata >> {off_q, 3'b000};
    assign h_word = mem_rdata >> {off_q[1], 4'b0000};

    always_comb begin
        load_res = mem_rdata;
        case (instr_q.mem_size)
            MEM_B:   load_res = instr_q.mem_unsigned ? {24'b0, b_word[7:0]}
                                                     : {{24{b_word[7]}}, b_word[7:0]};
            MEM_H:   load_res = instr_q.mem_unsigned ? {16'b0, h_word[15:0]}
                                                     : {{16{h_word[15]}}, h_word[15:0]};
            default: load_res = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        instr_d     = instr_q;
        rd1_d       = rd1_q;
        rd2_d       = rd2_q;
        out_data_d  = out_data_q;
        in_dvalid_d = in_dvalid_q;
        abort_d     = abort_q;
        off_d       = off_q;
        req_d       = req_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        tmo_d       = tmo_q;
        err_d       = 1'b0;

        case (state_q)
            S_REQ: begin
                if (mem_ack) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    if (instr_q.mem_op == MEM_LOAD && instr_q.reg_rd_src == RD_MEMORY)
                        out_data_d = load_res;
                end else if (timeout_hit) begin
                    state_d = S_DONE;
                    req_d   = 1'b0;
                    abort_d = 1'b1;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + CW'(1);
                end
            end
            S_DONE:  if (next_ready) state_d = S_IDLE;
            default: ;
        endcase

        // Capture only happens in IDLE or DONE, so it never races the REQ arm.
        if (capture) begin
            pc_d        = stage_in.pc;
            instr_d     = stage_in.instruction;
            rd1_d       = stage_in.reg_rd1;
            rd2_d       = stage_in.reg_rd2;
            out_data_d  = stage_in.data.data;
            in_dvalid_d = stage_in.data.valid;
            abort_d     = 1'b0;
            off_d       = in_off;
            tmo_d       = '0;
            addr_d      = {in_addr[31:2], 2'b00};
            we_d        = (stage_in.instruction.mem_op == MEM_STORE);
            wstrb_d     = 4'b0000;
            wdata_d     = rs2;
            case (stage_in.instruction.mem_size)
                MEM_B: begin
                    wdata_d = {4{rs2[7:0]}};
                    if (we_d) wstrb_d = 4'b0001 << in_off;
                end
                MEM_H: begin
                    wdata_d = {2{rs2[15:0]}};
                    if (we_d) wstrb_d = 4'b0011 << {in_off[1], 1'b0};
                end
                default: if (we_d) wstrb_d = 4'b1111;
            endcase

            if (stage_in.instruction.mem_op == MEM_NONE) begin
                state_d = S_DONE;
                req_d   = 1'b0;
            end else if (misalign) begin
                state_d = S_DONE;
                req_d   = 1'b0;
                abort_d = 1'b1;
                err_d   = 1'b1;
            end else begin
                state_d = S_REQ;
                req_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            instr_q     <= '0;
            rd1_q       <= '0;
            rd2_q       <= '0;
            out_data_q  <= '0;
            in_dvalid_q <= 1'b0;
            abort_q     <= 1'b0;
            off_q       <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            tmo_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            rd1_q       <= rd1_d;
            rd2_q       <= rd2_d;
            out_data_q  <= out_data_d;
            in_dvalid_q <= in_dvalid_d;
            abort_q     <= abort_d;
            off_q       <= off_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            tmo_q       <= tmo_d;
            err_q       <= err_d;
        end
    end

    // While in REQ the record shows rd with valid=0 so the hazard unit stalls.
    always_comb begin
        stage_out              = '0;
        stage_out.valid        = (state_q == S_DONE);
        stage_out.ready        = ready;
        stage_out.pc           = pc_q;
        stage_out.instruction  = instr_q;
        stage_out.reg_rd1      = rd1_q;
        stage_out.reg_rd2      = rd2_q;
        stage_out.data.valid   = (state_q == S_DONE) && !abort_q &&
                                 (in_dvalid_q || (instr_q.mem_op == MEM_LOAD));
        stage_out.data.address = instr_q.rd;
        stage_out.data.data    = out_data_q;
    end

    assign mem_req   = req_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_wstrb = wstrb_q;
    assign mem_error = err_q;
endmodule

// File: tb/tb_memory_access.sv
module tb_memory_access;
    import memory_access_pkg::*;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    stage_status_t stage_in;
    stage_status_t stage_out;
    logic          next_ready = 1'b0;
    logic          mem_req, mem_we, mem_error;
    logic [31:0]   mem_addr, mem_wdata;
    logic [3:0]    mem_wstrb;
    logic          mem_ack = 1'b0;
    logic [31:0]   mem_rdata = '0;

    int tests  = 0;
    int failed = 0;

    memory_access #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .stage_in(stage_in), .stage_out(stage_out),
        .next_ready(next_ready), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .mem_error(mem_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        mem_op_t     op;
        mem_size_t   sz;
        logic        uns;
        rd_src_t     src;
        logic [4:0]  rd;
        logic [31:0] addr;
        logic [31:0] rs2;
        logic        dv_in;
        logic [31:0] rdata;
        int          ack_at;    // REQ cycle in which ack is given, 0 = never
        int          exp_req;   // expected number of REQ cycles
        logic [31:0] exp_addr;
        logic        exp_we;
        logic [31:0] exp_wdata; // checked for stores only
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_data;
        logic        exp_dv;
        logic        exp_err;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add(input mem_op_t op, input mem_size_t sz, input logic uns, input rd_src_t src,
                       input logic [4:0] rd, input logic [31:0] addr, input logic [31:0] rs2,
                       input logic dv_in, input logic [31:0] rdata, input int ack_at,
                       input int exp_req, input logic [31:0] exp_addr, input logic exp_we,
                       input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                       input logic [31:0] exp_data, input logic exp_dv, input logic exp_err);
        vec_t v;
        v.op = op; v.sz = sz; v.uns = uns; v.src = src; v.rd = rd; v.addr = addr; v.rs2 = rs2;
        v.dv_in = dv_in; v.rdata = rdata; v.ack_at = ack_at; v.exp_req = exp_req;
        v.exp_addr = exp_addr; v.exp_we = exp_we; v.exp_wdata = exp_wdata;
        v.exp_wstrb = exp_wstrb; v.exp_data = exp_data; v.exp_dv = exp_dv; v.exp_err = exp_err;
        vecs.push_back(v);
    endtask

    task automatic drive(input mem_op_t op, input mem_size_t sz, input logic uns, input rd_src_t src,
                         input logic [4:0] rd, input logic [31:0] data, input logic [31:0] rs2,
                         input logic dv, input logic [31:0] pc);
        stage_in                          = '0;
        stage_in.valid                    = 1'b1;
        stage_in.pc                       = pc;
        stage_in.instruction.raw          = pc ^ 32'h0BAD_F00D;
        stage_in.instruction.rd           = rd;
        stage_in.instruction.reg_rd_src   = src;
        stage_in.instruction.mem_op       = op;
        stage_in.instruction.mem_size     = sz;
        stage_in.instruction.mem_unsigned = uns;
        stage_in.reg_rd1                  = ~rs2;
        stage_in.reg_rd2                  = rs2;
        stage_in.data.valid               = dv;
        stage_in.data.address             = rd;
        stage_in.data.data                = data;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int n;
        logic [31:0] pc;
        string t;
        t  = $sformatf("v%0d", idx);
        pc = 32'h1000 + 32'(idx * 4);
        @(negedge clk);
        drive(v.op, v.sz, v.uns, v.src, v.rd, v.addr, v.rs2, v.dv_in, pc);
        next_ready = 1'b0;
        @(negedge clk);
        stage_in.valid = 1'b0;
        n = 0;
        while (mem_req && n < 50) begin
            n++;
            if (n == 1) begin
                chk({t, ".addr"}, mem_addr, v.exp_addr);
                chk({t, ".we"}, 32'(mem_we), 32'(v.exp_we));
                chk({t, ".wstrb"}, 32'(mem_wstrb), 32'(v.exp_wstrb));
                if (v.op == MEM_STORE) chk({t, ".wdata"}, mem_wdata, v.exp_wdata);
                chk({t, ".req_dv"}, 32'(stage_out.data.valid), 32'd0);
                chk({t, ".req_rd"}, 32'(stage_out.data.address), 32'(v.rd));
            end
            mem_ack   = (n == v.ack_at);
            mem_rdata = v.rdata;
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk({t, ".req_cycles"}, 32'(n), 32'(v.exp_req));
        chk({t, ".valid"}, 32'(stage_out.valid), 32'd1);
        chk({t, ".err"}, 32'(mem_error), 32'(v.exp_err));
        chk({t, ".dv"}, 32'(stage_out.data.valid), 32'(v.exp_dv));
        chk({t, ".rd"}, 32'(stage_out.data.address), 32'(v.rd));
        chk({t, ".pc"}, stage_out.pc, pc);
        if (!v.exp_err) chk({t, ".data"}, stage_out.data.data, v.exp_data);
        next_ready = 1'b1;
        @(negedge clk);
        next_ready = 1'b0;
        chk({t, ".idle"}, 32'(stage_out.valid), 32'd0);
        chk({t, ".err_pulse"}, 32'(mem_error), 32'd0);
    endtask

    initial begin
        stage_in = '0;

        //  op         sz     uns   src        rd     addr          rs2           dv    rdata        ack req exp_addr     we    wdata         wstrb    data          dv   err
        add(MEM_LOAD,  MEM_W, 1'b0, RD_MEMORY, 5'd3,  32'h0000_0100, 32'h0,       1'b1, 32'hDEADBEEF, 3, 3, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hDEADBEEF, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_B, 1'b0, RD_MEMORY, 5'd4,  32'h0000_0103, 32'h0,       1'b1, 32'h80FFFFFF, 1, 1, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hFFFFFF80, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_B, 1'b1, RD_MEMORY, 5'd4,  32'h0000_0103, 32'h0,       1'b1, 32'h80FFFFFF, 1, 1, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h00000080, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_H, 1'b0, RD_MEMORY, 5'd6,  32'h0000_0102, 32'h0,       1'b1, 32'h80FFFFFF, 2, 2, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'hFFFF80FF, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_H, 1'b1, RD_MEMORY, 5'd7,  32'h0000_0100, 32'h0,       1'b1, 32'h12348765, 2, 2, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h00008765, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_B, 1'b0, RD_MEMORY, 5'd8,  32'h0000_0101, 32'h0,       1'b1, 32'h00007F00, 1, 1, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h0000007F, 1'b1, 1'b0);
        add(MEM_STORE, MEM_B, 1'b0, RD_ALU,    5'd0,  32'h0000_0201, 32'h12345678, 1'b0, 32'h0,       1, 1, 32'h0000_0200, 1'b1, 32'h78787878, 4'b0010, 32'h00000201, 1'b0, 1'b0);
        add(MEM_STORE, MEM_H, 1'b0, RD_ALU,    5'd0,  32'h0000_0302, 32'hAABBCCDD, 1'b0, 32'h0,       1, 1, 32'h0000_0300, 1'b1, 32'hCCDDCCDD, 4'b1100, 32'h00000302, 1'b0, 1'b0);
        add(MEM_STORE, MEM_W, 1'b0, RD_ALU,    5'd0,  32'h0000_0404, 32'hCAFEF00D, 1'b0, 32'h0,       2, 2, 32'h0000_0404, 1'b1, 32'hCAFEF00D, 4'b1111, 32'h00000404, 1'b0, 1'b0);
        add(MEM_NONE,  MEM_W, 1'b0, RD_ALU,    5'd5,  32'h0000_0055, 32'h0,       1'b1, 32'h0,        0, 0, 32'h0,         1'b0, 32'h0,        4'b0000, 32'h00000055, 1'b1, 1'b0);
        add(MEM_LOAD,  MEM_W, 1'b0, RD_MEMORY, 5'd9,  32'h0000_0500, 32'h0,       1'b1, 32'h0,        0, 8, 32'h0000_0500, 1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1);
`ifdef MEMORY_ACCESS_MISALIGN_EN
        add(MEM_LOAD,  MEM_W, 1'b0, RD_MEMORY, 5'd10, 32'h0000_0102, 32'h0,       1'b1, 32'h11223344, 1, 0, 32'h0,         1'b0, 32'h0,        4'b0000, 32'h0,        1'b0, 1'b1);
`else
        add(MEM_LOAD,  MEM_W, 1'b0, RD_MEMORY, 5'd10, 32'h0000_0102, 32'h0,       1'b1, 32'h11223344, 1, 1, 32'h0000_0100, 1'b0, 32'h0,        4'b0000, 32'h11223344, 1'b1, 1'b0);
`endif

        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state
        chk("rst.valid", 32'(stage_out.valid), 32'd0);
        chk("rst.ready", 32'(stage_out.ready), 32'd1);
        chk("rst.dv", 32'(stage_out.data.valid), 32'd0);
        chk("rst.data", stage_out.data.data, 32'd0);
        chk("rst.pc", stage_out.pc, 32'd0);
        chk("rst.req", 32'(mem_req), 32'd0);
        chk("rst.addr", mem_addr, 32'd0);
        chk("rst.wdata", mem_wdata, 32'd0);
        chk("rst.wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst.err", 32'(mem_error), 32'd0);

        foreach (vecs[i]) run_vec(i, vecs[i]);

        // Back-to-back ALU ops with writeback always ready.
        @(negedge clk);
        next_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(MEM_NONE, MEM_W, 1'b0, RD_ALU, 5'(k + 1), 32'h100 + 32'(k), 32'h0, 1'b1, 32'h2000 + 32'(k * 4));
            @(negedge clk);
            chk($sformatf("b2b%0d.valid", k), 32'(stage_out.valid), 32'd1);
            chk($sformatf("b2b%0d.ready", k), 32'(stage_out.ready), 32'd1);
            chk($sformatf("b2b%0d.data", k), stage_out.data.data, 32'h100 + 32'(k));
            chk($sformatf("b2b%0d.rd", k), 32'(stage_out.data.address), 32'(k + 1));
        end
        stage_in.valid = 1'b0;
        @(negedge clk);
        next_ready = 1'b0;
        chk("b2b.idle", 32'(stage_out.valid), 32'd0);

        // Writeback stall in DONE: outputs hold, new input waits.
        drive(MEM_NONE, MEM_W, 1'b0, RD_ALU, 5'd12, 32'h77, 32'h0, 1'b1, 32'h3000);
        @(negedge clk);
        drive(MEM_NONE, MEM_W, 1'b0, RD_ALU, 5'd13, 32'h99, 32'h0, 1'b1, 32'h3004);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("stall%0d.valid", k), 32'(stage_out.valid), 32'd1);
            chk($sformatf("stall%0d.ready", k), 32'(stage_out.ready), 32'd0);
            chk($sformatf("stall%0d.data", k), stage_out.data.data, 32'h77);
            chk($sformatf("stall%0d.pc", k), stage_out.pc, 32'h3000);
            @(negedge clk);
        end
        next_ready = 1'b1;
        @(negedge clk);
        stage_in.valid = 1'b0;
        chk("stall.next_data", stage_out.data.data, 32'h99);
        chk("stall.next_rd", 32'(stage_out.data.address), 32'd13);
        @(negedge clk);
        next_ready = 1'b0;

        // Reset in the middle of REQ, then a late ack that must be ignored.
        drive(MEM_LOAD, MEM_W, 1'b0, RD_MEMORY, 5'd7, 32'h600, 32'h0, 1'b1, 32'h4000);
        @(negedge clk);
        stage_in.valid = 1'b0;
        chk("mid.req", 32'(mem_req), 32'd1);
        chk("mid.ready", 32'(stage_out.ready), 32'd0);
        chk("mid.dv", 32'(stage_out.data.valid), 32'd0);
        chk("mid.rd", 32'(stage_out.data.address), 32'd7);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rreq.req", 32'(mem_req), 32'd0);
        chk("rreq.valid", 32'(stage_out.valid), 32'd0);
        mem_ack   = 1'b1;
        mem_rdata = 32'hBADBAD00;
        @(negedge clk);
        mem_ack = 1'b0;
        chk("late.valid", 32'(stage_out.valid), 32'd0);
        chk("late.req", 32'(mem_req), 32'd0);
        chk("late.ready", 32'(stage_out.ready), 32'd1);
        chk("late.data", stage_out.data.data, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
